decompress_unpack: RTL and testbench

Byte-stream unpacker that sits directly upstream of the Kyber decompress stage. It takes serialized ciphertext bytes (u or v components, or the message) and assembles them into groups of 8 packed d-bit coefficients for d = 1, 4 or 10. It presents each group on the bus widths decompress consumes, with a valid/ready handshake. One start transaction covers one polynomial: 256 coefficients, i.e. 32 groups.

---
 rtl/decompress_unpack.sv | 134 +++++++++++++
 tb/tb_decompress_unpack.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decompress_unpack.sv
`default_nettype none
// ============================================================================
// Module      : decompress_unpack
// Description : Byte-stream unpacker feeding the Kyber decompress stage.
//               Collects 1, 4 or 10 little-endian bytes per group (d = 1, 4
//               or 10) and presents each group of 8 packed coefficients with
//               a valid/ready handshake; one start covers one polynomial.
// Revision    : 1.0 - initial release
// ============================================================================
module decompress_unpack #(
    parameter int N_GROUPS  = 32,
    parameter int MAX_BYTES = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             d_in,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             d,
    output logic [7:0]             in_data_d1,
    output logic [31:0]            in_data_d4,
    output logic [8*MAX_BYTES-1:0] in_data_d10,
    output logic                   busy,
    output logic                   done
);

    localparam int          GW         = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
    localparam int          BW         = 8 * MAX_BYTES;
    localparam logic [GW-1:0] LAST_GROUP = GW'(N_GROUPS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] buffer;
    logic [3:0]    byte_cnt;
    logic [GW-1:0] group_cnt;
    logic [3:0]    bpg;
    logic          start_ok;
    logic          byte_take;
    logic          group_take;
    logic          last_byte;
    logic          last_group;

    // Bytes per group: anything other than 1 or 4 groups like d=10.
    always_comb begin
        bpg = 4'd10;
        if (d == 4'd1)      bpg = 4'd1;
        else if (d == 4'd4) bpg = 4'd4;
    end

    // A start landing on the done cycle belongs to the finishing polynomial
    // and is dropped, so done gates acceptance in IDLE.
    assign start_ok   = (state == ST_IDLE) && start && !done;
    assign byte_take  = (state == ST_LOAD) && in_valid;
    assign group_take = (state == ST_EMIT) && out_ready;
    assign last_byte  = (byte_cnt == (bpg - 4'd1));
    assign last_group = (group_cnt == LAST_GROUP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok) state_nxt = ST_LOAD;
            ST_LOAD: if (byte_take && last_byte) state_nxt = ST_EMIT;
            ST_EMIT: if (out_ready) state_nxt = last_group ? ST_IDLE : ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: width latch, byte assembly, counters and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            d         <= 4'd0;
            buffer    <= '0;
            byte_cnt  <= 4'd0;
            group_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= group_take && last_group;
            if (start_ok) begin
                d         <= d_in;
                buffer    <= '0;
                byte_cnt  <= 4'd0;
                group_cnt <= '0;
            end else if (byte_take) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (byte_cnt == i[3:0]) buffer[8*i +: 8] <= in_byte;
                end
                byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
            end else if (group_take) begin
                // Clearing here keeps unused upper bytes of the next group at 0.
                buffer    <= '0;
                group_cnt <= group_cnt + 1'b1;
            end
        end
    end

    assign in_data_d1  = buffer[7:0];
    assign in_data_d4  = buffer[31:0];
    assign in_data_d10 = buffer;

endmodule
`default_nettype wire

// File: tb/tb_decompress_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_decompress_unpack
// Description : Self-checking bench for decompress_unpack with a byte-level
//               reference model of group assembly and the handshake protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decompress_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  d_in;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  d;
    logic [7:0]  in_data_d1;
    logic [31:0] in_data_d4;
    logic [79:0] in_data_d10;
    logic        busy;
    logic        done;

    int vectors = 0;
    int errors  = 0;

    decompress_unpack #(.N_GROUPS(32), .MAX_BYTES(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .d_in       (d_in),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .d          (d),
        .in_data_d1 (in_data_d1),
        .in_data_d4 (in_data_d4),
        .in_data_d10(in_data_d10),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pattern(input int mode, input int idx);
        logic [7:0] lo;
        logic [7:0] hi;
        case (mode)
            0: pattern = idx[7:0];
            1: pattern = idx[7:0] + 8'd1;
            2: begin
                lo = 8'(2 * idx);
                hi = 8'(2 * idx + 1);
                pattern = {hi[3:0], lo[3:0]};
            end
            default: pattern = 8'($urandom_range(0, 255));
        endcase
    endfunction

    function automatic int bytes_per_group(input logic [3:0] dv);
        if (dv == 4'd1) return 1;
        if (dv == 4'd4) return 4;
        return 10;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; d_in = 4'd0; in_byte = 8'd0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, busy, done, d, in_data_d10} !== 88'd0)
            begin errors++; $display("FAIL reset_state: rdy=%b vld=%b busy=%b done=%b d=%0d buf=%h, required all 0",
                in_ready, out_valid, busy, done, d, in_data_d10); end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000)
            begin errors++; $display("FAIL idle_after_reset: rdy=%b vld=%b busy=%b done=%b, required 0000",
                in_ready, out_valid, busy, done); end
    endtask

    // Full polynomial against the model: bytes are collected bpg at a time,
    // concatenated little-endian, and each group must appear the cycle after
    // its last byte and stay stable until taken.
    task automatic run_poly(input logic [3:0] dv, input int mode, input int stall_pct,
                            input int gap_pct, input bit spur);
        int bpg = bytes_per_group(dv);
        int sent = 0;
        int groups = 0;
        int nb = 0;
        int cyc = 0;
        bit emitting = 0;
        bit fin = 0;
        logic [79:0] exp_grp = '0;
        @(negedge clk);
        d_in = dv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || d !== dv)
            begin errors++; $display("FAIL start_accept: busy=%b rdy=%b vld=%b d=%0d, required 1 1 0 d=%0d",
                busy, in_ready, out_valid, d, dv); end
        while (!fin && cyc < 20000) begin
            vectors++;
            if (emitting) begin
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || in_data_d10 !== exp_grp ||
                    in_data_d4 !== exp_grp[31:0] || in_data_d1 !== exp_grp[7:0] || d !== dv || done !== 1'b0)
                    begin errors++; $display("FAIL emit_grp%0d: vld=%b rdy=%b data=%h d=%0d done=%b, required 1 0 %h d=%0d 0",
                        groups, out_valid, in_ready, in_data_d10, d, done, exp_grp, dv); end
            end else begin
                if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
                    begin errors++; $display("FAIL load_grp%0d: rdy=%b vld=%b busy=%b done=%b, required 1 0 1 0",
                        groups, in_ready, out_valid, busy, done); end
            end
            start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            if (spur && $urandom_range(0, 9) == 0) begin start = 1'b1; d_in = 4'd4; end
            if (emitting) begin
                out_ready = ($urandom_range(0, 99) >= stall_pct);
                in_valid  = 1'($urandom_range(0, 1));
                in_byte   = 8'($urandom_range(0, 255));
                if (out_ready) begin
                    groups++; emitting = 0; nb = 0; exp_grp = '0;
                    if (groups == 32) fin = 1;
                end
            end else begin
                in_valid = ($urandom_range(0, 99) >= gap_pct);
                in_byte  = pattern(mode, sent);
                if (in_valid) begin
                    exp_grp = exp_grp | ({72'd0, in_byte} << (8 * nb));
                    nb++; sent++;
                    if (nb == bpg) emitting = 1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (!fin)
            begin errors++; $display("FAIL poly_timeout: groups=%0d, required 32", groups); end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || d !== dv || sent !== 32 * bpg)
            begin errors++; $display("FAIL done_pulse: done=%b busy=%b rdy=%b vld=%b d=%0d bytes=%0d, required 1 0 0 0 d=%0d bytes=%0d",
                done, busy, in_ready, out_valid, d, sent, dv, 32 * bpg); end
        // A start coinciding with done must be ignored.
        start = 1'b1; d_in = 4'd1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || d !== dv)
            begin errors++; $display("FAIL after_done: done=%b busy=%b rdy=%b d=%0d, required 0 0 0 d=%0d",
                done, busy, in_ready, d, dv); end
    endtask

    task automatic test_backpressure();
        logic [7:0] grp0 [4] = '{8'h10, 8'h32, 8'h54, 8'h76};
        @(negedge clk);
        d_in = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = grp0[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || in_data_d4 !== 32'h76543210 || d !== 4'd4 || in_data_d10[79:32] !== 48'd0)
            begin errors++; $display("FAIL bp_first_group: vld=%b data=%h d=%0d, required 1 76543210 d=4",
                out_valid, in_data_d10, d); end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_byte = 8'hEE; out_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || in_data_d10 !== 80'h76543210)
                begin errors++; $display("FAIL bp_stall%0d: vld=%b rdy=%b data=%h, required 1 0 76543210",
                    c, out_valid, in_ready, in_data_d10); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_data_d10 !== 80'd0)
            begin errors++; $display("FAIL bp_resume: rdy=%b vld=%b data=%h, required 1 0 0",
                in_ready, out_valid, in_data_d10); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_byte = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || in_data_d10 !== 80'hA3A2A1A0)
            begin errors++; $display("FAIL bp_second_group: vld=%b data=%h, required 1 a3a2a1a0",
                out_valid, in_data_d10); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_in = 4'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_byte = 8'h5A ^ 8'(i);
            @(negedge clk);
        end
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, busy, done, d, in_data_d10} !== 88'd0)
            begin errors++; $display("FAIL mid_reset: rdy=%b vld=%b busy=%b done=%b d=%0d buf=%h, required all 0",
                in_ready, out_valid, busy, done, d, in_data_d10); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL mid_reset_quiet%0d: done=%b busy=%b, required 0 0", c, done, busy); end
        end
        run_poly(4'd1, 3, 20, 20, 1'b0);
    endtask

    initial begin
        test_reset();
        run_poly(4'd1, 0, 0, 0, 1'b0);      // bytes 0x00..0x1F, no stalls
        run_poly(4'd4, 2, 0, 0, 1'b0);      // first group 0x76543210
        run_poly(4'd10, 1, 0, 0, 1'b0);     // first group 0x0A..0x01
        test_backpressure();
        test_reset_mid();
        run_poly(4'd10, 3, 30, 30, 1'b1);   // spurious starts with d_in=4 while busy
        run_poly(4'd7, 3, 25, 25, 1'b0);    // unusual width groups like d=10
        run_poly(4'd4, 3, 40, 40, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
